button_event_decoder: RTL
=========================

# button_event_decoder

Consumer-side partner of the button debouncer. Takes the debounced single-cycle press/release pulses and classifies each press as SHORT, LONG or auto-REPEAT. Queues the resulting events in a 4-entry FIFO. The game control FSM pops events with a valid/ack handshake, so presses arriving while the game logic is busy (dealing, scoring) are not lost.

## Interface
Parameters:
- LONG_TICKS, default 2000, clock cycles of continuous hold before a LONG event (1 s at 2 kHz); legal range ≥ 2.
- REPEAT_TICKS, default 400, cycles between REPEAT events once LONG has fired (200 ms at 2 kHz); legal range ≥ 2.

Ports:
- i_Clk_2kHz  input  1  system tick clock, rising-edge. One clock; reset is asynchronous and active-high.
- i_Reset  input  1  asynchronous, active-high reset.
- i_ButtonDown  input  1  one-cycle press pulse from the debouncer.
- i_ButtonUp  input  1  one-cycle release pulse from the debouncer.
- i_Ack  input  1  consumer pops the head event when high with o_Valid.
- o_Valid  output  1  FIFO non-empty; head event on o_EventCode.
- o_EventCode  output  2  head event: 01 SHORT, 10 LONG, 11 REPEAT (00 never queued).
- o_Count  output  3  FIFO occupancy, 0..4.
- o_Overflow  output  1  sticky: an event was dropped on a full FIFO.
- o_Held  output  1  high while the classifier is in PRESSED or HELD.

## Operation
- Reset (async assert) forces classifier state IDLE, hold counter 0, FIFO empty, o_Valid=0, o_EventCode=00, o_Count=0, o_Overflow=0, o_Held=0.
- Classifier FSM, evaluated each rising edge:
  - IDLE: on i_ButtonDown=1 (and i_ButtonUp=0), go to PRESSED and clear the counter. All other input combinations are ignored.
  - PRESSED:
    - i_ButtonUp=1: push SHORT, go to IDLE.
    - Else, counter = LONG_TICKS-1: push LONG, go to HELD, clear the counter.
    - Else: increment the counter.
  - HELD:
    - i_ButtonUp=1: go to IDLE, no event.
    - Else, counter = REPEAT_TICKS-1: push REPEAT, clear the counter.
    - Else: increment the counter.
- Priority rules:
  - i_ButtonUp beats a threshold match in the same cycle. In PRESSED this yields SHORT; in HELD it yields no REPEAT.
  - i_ButtonDown outside IDLE is ignored.
  - i_ButtonDown and i_ButtonUp high together are treated as neither.
- Counter width is clog2(max(LONG_TICKS, REPEAT_TICKS)) bits. It never wraps, because it is cleared at the threshold.
- FIFO: 4 entries × 2 bits, circular, with 2-bit read/write pointers that wrap 3→0 and a 3-bit count.
  - Pop occurs when o_Valid & i_Ack. i_Ack with o_Valid=0 is ignored.
  - Push and pop in the same cycle are both performed; the count is unchanged, including when the FIFO is full.
  - Push while full without a pop: the event is dropped, o_Overflow is set to 1, and FIFO contents are unchanged. o_Overflow clears only on reset.
- o_EventCode shows the head entry when o_Valid=1 and is 00 when empty.

## Timing
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.
- Event latency: a condition sampled at edge N is written at edge N. o_Valid and o_EventCode update after edge N, visible in cycle N+1.
- LONG timing: with i_ButtonDown sampled at edge 0 and no release, LONG is pushed at edge LONG_TICKS. REPEATs follow at edges LONG_TICKS + k·REPEAT_TICKS, for k ≥ 1.
- Pop: head advances after the edge where o_Valid & i_Ack. The consumer may hold i_Ack high to drain one entry per cycle.
- o_Held rises the cycle after the press edge and falls the cycle after the release edge.
- Reset asserted mid-hold or mid-drain: everything returns to reset values immediately. No event is emitted on the first edge after deassertion unless the inputs call for one.

## Test plan
Sim parameters: LONG_TICKS=8, REPEAT_TICKS=4.
- Short press: Down at edge 0, Up at edge 3 → SHORT (01) at head from cycle 4, o_Count=1. Ack at edge 5 → o_Valid=0, o_Count=0.
- Long + repeat: Down at edge 0, held → LONG at edge 8, REPEAT at edges 12 and 16. Up at edge 18 → no further event, o_Count=3, order 10,11,11.
- Tie: Down at edge 0, Up at edge 8 → exactly one SHORT, no LONG. Held with Up at edge 12 → LONG only, no REPEAT.
- Overflow: hold with i_Ack=0 until 5 events are generated → o_Count=4, o_Overflow=1, and the 4 oldest drain in order. Repeat with i_Ack=1 on the full-FIFO push cycle → count stays 4, o_Overflow stays 0.
- Reset mid-hold: Down at edge 0, i_Reset pulse at cycle 5 → all outputs 0 at once. Held button gives no event until a new Down.
- Ignored inputs: Up in IDLE, Down while PRESSED, and Down+Up together in IDLE → no state change, o_Count stays 0.

Source files
------------

// File: rtl/button_event_decoder.sv
// Classifies debounced press/release pulses into SHORT, LONG and REPEAT events
// and queues them in a 4-deep FIFO popped by a valid/ack consumer.
module button_event_decoder #(
    parameter int LONG_TICKS   = 2000,
    parameter int REPEAT_TICKS = 400
) (
    input  logic       i_Clk_2kHz,
    input  logic       i_Reset,
    input  logic       i_ButtonDown,
    input  logic       i_ButtonUp,
    input  logic       i_Ack,
    output logic       o_Valid,
    output logic [1:0] o_EventCode,
    output logic [2:0] o_Count,
    output logic       o_Overflow,
    output logic       o_Held
);
    // state   | meaning
    // IDLE    | button released, waiting for a press
    // PRESSED | pressed, timing toward LONG
    // HELD    | LONG fired, emitting REPEAT every REPEAT_TICKS
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
    localparam logic [1:0] EV_REPEAT = 2'b11;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_push;
    logic [1:0]       w_push_code;

    // Down and Up together cancel each other out.
    logic w_down;
    logic w_up;
    assign w_down = i_ButtonDown & ~i_ButtonUp;
    assign w_up   = i_ButtonUp & ~i_ButtonDown;

    always_ff @(posedge i_Clk_2kHz or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_push       = 1'b0;
        w_push_code  = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_down) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                end
            end
            PRESSED: begin
                if (w_up) begin
                    w_push       = 1'b1;
                    w_push_code  = EV_SHORT;
                    w_state_next = IDLE;
                end else if (r_cnt == LONG_LAST) begin
                    w_push       = 1'b1;
                    w_push_code  = EV_LONG;
                    w_state_next = HELD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (w_up) begin
                    w_state_next = IDLE;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_push      = 1'b1;
                    w_push_code = EV_REPEAT;
                    w_cnt_next  = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    logic [1:0] r_mem [0:3];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic       r_overflow;
    logic       w_full;
    logic       w_pop;
    logic       w_wr_en;

    assign w_full  = (r_count == 3'd4);
    assign w_pop   = o_Valid & i_Ack;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge i_Clk_2kHz or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= 2'b00;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_push_code;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_Valid     = (r_count != 3'd0);
    assign o_EventCode = o_Valid ? r_mem[r_rd_ptr] : 2'b00;
    assign o_Count     = r_count;
    assign o_Overflow  = r_overflow;
    assign o_Held      = (r_state != IDLE);

endmodule
